// File: rtl/datapath_pkg.sv
// Shared types for the sequenced single-bus datapath: opcodes, FSM states and a
// ceiling-log2 helper used to size address and shift fields.
package datapath_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpShr = 4'd4,
    OpShl = 4'd5,
    OpNeg = 4'd6,
    OpNot = 4'd7,
    OpMul = 4'd8,
    OpDiv = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLdy,
    StExec,
    StIter,
    StWb,
    StDone
  } state_e;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-bit-per-cycle unsigned shift-add multiply / restoring divide step over a
// 2*DATA_W accumulator {hi, lo}; the accumulator itself is the caller's Z register.
module iter_muldiv
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_init,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic [DATA_W-1:0]     i_b,
  input  logic [2*DATA_W-1:0]   i_acc,
  output logic [2*DATA_W-1:0]   o_acc,
  output logic                  o_last
);

  localparam int unsigned CntW = log2(DATA_W) + 1;

  logic [CntW-1:0]   r_count;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] w_hi, w_lo, w_trial;
  logic [DATA_W:0]   w_sum, w_shift;

  assign w_hi    = i_acc[2*DATA_W-1:DATA_W];
  assign w_lo    = i_acc[DATA_W-1:0];
  assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {w_hi, w_lo[DATA_W-1]};
  // Only used when shift >= divisor, so the true difference fits in DATA_W bits.
  assign w_trial = w_shift[DATA_W-1:0] - r_b;

  always_comb begin
    o_acc = '0;
    if (i_is_div) begin
      // A zero divisor always "fits": quotient all-ones, remainder = dividend.
      if (w_shift >= {1'b0, r_b}) o_acc = {w_trial, w_lo[DATA_W-2:0], 1'b1};
      else                        o_acc = {w_shift[DATA_W-1:0], w_lo[DATA_W-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, w_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
      r_b     <= '0;
    end else if (i_init) begin
      r_count <= CntW'(DATA_W);
      r_b     <= i_b;
    end else if (i_step && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == CntW'(1));

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with register file, Y, Z, HI and LO, driven by an internal
// micro-step sequencer for three-operand instructions including iterative MUL/DIV.
module bus_datapath_seq
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter bit          R0_ZERO  = 1'b0,
  localparam int unsigned AW      = log2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     rc,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ShW = log2(DATA_W);

  state_e              r_state, w_state_next;
  logic [3:0]          r_op;
  logic [AW-1:0]       r_ra, r_rb, r_rc;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_y, r_hi, r_lo;
  logic [2*DATA_W-1:0] r_z, w_iter_z;
  logic [DATA_W-1:0]   w_bus, w_alu, w_wr_data;
  logic [AW-1:0]       w_wr_addr;
  logic                w_is_iter, w_iter_last, w_wr_en;

  assign w_is_iter = (r_op == OpMul) || (r_op == OpDiv);
  assign w_bus     = (r_state == StLdy) ? r_regs[r_ra] : r_regs[r_rb];

  always_comb begin
    w_alu = '0;
    case (r_op)
      OpAdd:   w_alu = r_y + w_bus;
      OpSub:   w_alu = r_y - w_bus;
      OpAnd:   w_alu = r_y & w_bus;
      OpOr:    w_alu = r_y | w_bus;
      OpShr:   w_alu = r_y >> w_bus[ShW-1:0];
      OpShl:   w_alu = r_y << w_bus[ShW-1:0];
      OpNeg:   w_alu = -w_bus;
      OpNot:   w_alu = ~w_bus;
      default: w_alu = '0;
    endcase
  end

  iter_muldiv #(
    .DATA_W (DATA_W)
  ) u_iter_muldiv (
    .i_clk    (clock),
    .i_clear  (clear),
    .i_init   ((r_state == StExec) && w_is_iter),
    .i_step   (r_state == StIter),
    .i_is_div (r_op == OpDiv),
    .i_b      (w_bus),
    .i_acc    (r_z),
    .o_acc    (w_iter_z),
    .o_last   (w_iter_last)
  );

  // External loads and write-back never coincide: loads happen only in IDLE.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = ld_addr;
    w_wr_data = ld_data;
    if ((r_state == StIdle) && ld_en) begin
      w_wr_en = 1'b1;
    end else if ((r_state == StWb) && (r_op <= OpDiv)) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_rc;
      w_wr_data = r_z[DATA_W-1:0];
    end
    if (R0_ZERO && (w_wr_addr == '0)) w_wr_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_op <= '0;
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
      r_y  <= '0;
      r_z  <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_op <= op;
            r_ra <= ra;
            r_rb <= rb;
            r_rc <= rc;
          end
        end
        StLdy:  r_y <= w_bus;
        StExec: r_z <= {{DATA_W{1'b0}}, (w_is_iter ? r_y : w_alu)};
        StIter: r_z <= w_iter_z;
        StWb: begin
          if (w_is_iter) begin
            r_hi <= r_z[2*DATA_W-1:DATA_W];
            r_lo <= r_z[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StLdy;
      StLdy:   w_state_next = StExec;
      StExec:  w_state_next = w_is_iter ? StIter : StWb;
      StIter:  if (w_iter_last) w_state_next = StWb;
      StWb:    w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign rd_data = r_regs[rd_addr];
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StDone);

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench: a 32-bit/16-register instance for the main function and an
// 8-register R0_ZERO instance for the hard-wired-zero register.
module tb_bus_datapath_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, start, ld_en, busy, done;
  logic [3:0]  op, ra, rb, rc, ld_addr, rd_addr;
  logic [31:0] ld_data, rd_data, hi, lo;

  logic        start_s, ld_en_s, busy_s, done_s;
  logic [3:0]  op_s;
  logic [2:0]  ra_s, rb_s, rc_s, ld_addr_s, rd_addr_s;
  logic [31:0] ld_data_s, rd_data_s, hi_s, lo_s;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b0)) u_dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(8), .R0_ZERO(1'b1)) u_dut_z (
    .clock(clock), .clear(clear), .start(start_s), .op(op_s), .ra(ra_s), .rb(rb_s),
    .rc(rc_s), .ld_en(ld_en_s), .ld_addr(ld_addr_s), .ld_data(ld_data_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s), .hi(hi_s), .lo(lo_s), .busy(busy_s),
    .done(done_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Issues one instruction; returns cycles from the start cycle to the done cycle.
  task automatic run_op(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, output int cycles);
    op = o; ra = a; rb = b; rc = c; start = 1'b1;
    tick();
    start = 1'b0; ld_en = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    tick();
  endtask

  task automatic run_op_s(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] c, output int cycles);
    op_s = o; ra_s = a; rb_s = b; rc_s = c; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cycles = 1;
    while (done_s !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    tick();
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; ld_en = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    ld_addr = '0; ld_data = '0; rd_addr = '0;
    start_s = 1'b0; ld_en_s = 1'b0; op_s = '0; ra_s = '0; rb_s = '0; rc_s = '0;
    ld_addr_s = '0; ld_data_s = '0; rd_addr_s = '0;
    tick();
    tick();
    clear = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check_reg("rst_r5", 4'd5, 0);

    load(4'd1, 32'd7);
    load(4'd2, 32'd5);
    check_reg("load_r1", 4'd1, 32'd7);

    op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("add_busy_e0", busy, 1);
    check("add_done_e0", done, 0);
    tick(); tick();
    check("add_done_e2", done, 0);
    tick();
    check("add_done_e3", done, 1);
    check_reg("add_r3", 4'd3, 32'd12);
    tick();
    check("add_done_fall", done, 0);
    check("add_busy_fall", busy, 0);

    run_op(4'd1, 4'd1, 4'd2, 4'd4, lat);
    check("sub_lat", lat, 4);
    check_reg("sub_r4", 4'd4, 32'd2);

    load(4'd5, 32'hFFFF_FFFF);
    load(4'd6, 32'd2);
    run_op(4'd8, 4'd5, 4'd6, 4'd7, lat);
    check("mul_lat", lat, 36);
    check("mul_hi", hi, 32'd1);
    check("mul_lo", lo, 32'hFFFF_FFFE);
    check_reg("mul_r7", 4'd7, 32'hFFFF_FFFE);

    load(4'd8, 32'd100);
    load(4'd9, 32'd7);
    run_op(4'd9, 4'd8, 4'd9, 4'd10, lat);
    check("div_lat", lat, 36);
    check("div_lo", lo, 32'd14);
    check("div_hi", hi, 32'd2);
    check_reg("div_r10", 4'd10, 32'd14);

    load(4'd11, 32'd9);
    run_op(4'd9, 4'd11, 4'd0, 4'd12, lat);
    check("div0_lat", lat, 36);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd9);
    check_reg("div0_r12", 4'd12, 32'hFFFF_FFFF);

    // Load to ra in the start cycle: the add must see the new R1.
    ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd20;
    run_op(4'd0, 4'd1, 4'd2, 4'd3, lat);
    check("ldstart_r3", lat == 4 ? 32'd0 : 32'd1, 0);
    check_reg("ldstart_sum", 4'd3, 32'd25);
    check_reg("ldstart_r1", 4'd1, 32'd20);

    // start and ld_en while busy are both dropped.
    op = 4'd8; ra = 4'd5; rb = 4'd6; rc = 4'd13; start = 1'b1;
    tick();
    ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'd99;
    op = 4'd0; ra = 4'd1; rb = 4'd1; rc = 4'd14;
    tick(); tick(); tick();
    check("ign_busy", busy, 1);
    ld_en = 1'b0; start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("ign_lat", lat, 36);
    tick();
    check("ign_idle", busy, 0);
    tick(); tick();
    check("ign_no_queue", busy, 0);
    check_reg("ign_r2", 4'd2, 32'd5);
    check_reg("ign_r13", 4'd13, 32'hFFFF_FFFE);
    check_reg("ign_r14", 4'd14, 32'd0);

    load(4'd15, 32'd33);
    run_op(4'd5, 4'd1, 4'd15, 4'd3, lat);
    check_reg("shl_r3", 4'd3, 32'd40);
    run_op(4'd4, 4'd1, 4'd15, 4'd4, lat);
    check_reg("shr_r4", 4'd4, 32'd10);
    run_op(4'd2, 4'd1, 4'd2, 4'd6, lat);
    check_reg("and_r6", 4'd6, 32'd4);
    run_op(4'd3, 4'd1, 4'd2, 4'd8, lat);
    check_reg("or_r8", 4'd8, 32'd21);
    run_op(4'd6, 4'd1, 4'd2, 4'd9, lat);
    check_reg("neg_r9", 4'd9, 32'hFFFF_FFFB);
    run_op(4'd7, 4'd1, 4'd2, 4'd10, lat);
    check_reg("not_r10", 4'd10, 32'hFFFF_FFFA);

    run_op(4'd12, 4'd1, 4'd2, 4'd3, lat);
    check("nop_lat", lat, 4);
    check_reg("nop_r3", 4'd3, 32'd40);

    run_op(4'd0, 4'd1, 4'd2, 4'd1, lat);
    check_reg("self_r1", 4'd1, 32'd25);

    // Abort a multiply in ITER with clear.
    op = 4'd8; ra = 4'd5; rb = 4'd6; rc = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("clr_pre_busy", busy, 1);
    check("clr_pre_hi", hi, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_hi", hi, 0);
    check("clr_lo", lo, 0);
    for (int i = 0; i < 16; i++) check_reg($sformatf("clr_r%0d", i), 4'(i), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("clr_nodone%0d", i), done, 0);
    end

    // R0_ZERO instance.
    ld_en_s = 1'b1; ld_addr_s = 3'd0; ld_data_s = 32'd55;
    tick();
    ld_addr_s = 3'd1; ld_data_s = 32'd3;
    tick();
    ld_addr_s = 3'd2; ld_data_s = 32'd4;
    tick();
    ld_en_s = 1'b0;
    rd_addr_s = 3'd0; #1;
    check("z_load_r0", rd_data_s, 0);
    run_op_s(4'd0, 3'd1, 3'd2, 3'd0, lat);
    check("z_wb_lat", lat, 4);
    rd_addr_s = 3'd0; #1;
    check("z_wb_r0", rd_data_s, 0);
    run_op_s(4'd0, 3'd1, 3'd2, 3'd3, lat);
    rd_addr_s = 3'd3; #1;
    check("z_wb_r3", rd_data_s, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
